// File: rtl/tilemap_scheduler.sv
// Tile-map walker: reads a COLS x ROWS map from synchronous RAM and issues one
// drawer request per non-transparent cell, waiting for the drawer to finish each tile.
module tilemap_scheduler #(
  parameter int unsigned COLS       = 20,
  parameter int unsigned ROWS       = 15,
  parameter int unsigned TILE_BYTES = 192,
  parameter int unsigned NUM_TILES  = 21,
  parameter int unsigned SKIP_INDEX = 31,
  parameter int unsigned WATCHDOG   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  map_data,
  input  logic        active,
  output logic [8:0]  map_address,
  output logic [11:0] tile_address,
  output logic [7:0]  x_pos,
  output logic [7:0]  y_pos,
  output logic        draw,
  output logic        busy,
  output logic        frame_done
);

  localparam int unsigned WDW = (WATCHDOG > 2) ? $clog2(WATCHDOG) : 1;

  localparam logic [4:0]     COL_LAST = 5'(COLS - 1);
  localparam logic [4:0]     ROW_LAST = 5'(ROWS - 1);
  localparam logic [4:0]     SKIP     = 5'(SKIP_INDEX);
  localparam logic [4:0]     NUM_T    = 5'(NUM_TILES);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(WATCHDOG - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_NEXT,
    S_DONE
  } state_t;

  state_t         state;
  state_t         state_next;
  logic [4:0]     row;
  logic [4:0]     col;
  logic [WDW-1:0] wdog;
  logic           last_cell;
  logic           wd_expire;
  logic [4:0]     tile_idx;
  logic [16:0]    tile_prod;

  always_comb begin
    last_cell = (row == ROW_LAST) && (col == COL_LAST);
    // The draw cycle and the current cycle both count, so a re-issue lands
    // exactly WATCHDOG cycles after the unanswered draw.
    wd_expire = (wdog == WD_LIMIT);
    tile_idx  = (map_data < NUM_T) ? map_data : '0;
    tile_prod = 17'(tile_idx) * 17'(TILE_BYTES);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    draw       = 1'b0;
    busy       = (state != S_IDLE);
    frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_FETCH;
      end
      S_FETCH: begin
        state_next = S_LATCH;
      end
      S_LATCH: begin
        state_next = (map_data == SKIP) ? S_NEXT : S_ISSUE;
      end
      S_ISSUE: begin
        if (!active) begin
          draw       = 1'b1;
          state_next = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (active) begin
          state_next = S_WAIT_DONE;
        end else if (wd_expire) begin
          state_next = S_ISSUE;
        end
      end
      S_WAIT_DONE: begin
        if (!active) state_next = S_NEXT;
      end
      S_NEXT: begin
        state_next = last_cell ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        frame_done = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_address  <= '0;
      tile_address <= '0;
      x_pos        <= '0;
      y_pos        <= '0;
      row          <= '0;
      col          <= '0;
      wdog         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            row         <= '0;
            col         <= '0;
            map_address <= '0;
          end
        end
        S_LATCH: begin
          if (map_data != SKIP) begin
            tile_address <= tile_prod[11:0];
            x_pos        <= 8'({col, 3'b000});
            y_pos        <= 8'({row, 3'b000});
          end
        end
        S_ISSUE: begin
          if (!active) wdog <= '0;
        end
        S_WAIT_ACK: begin
          if (!active) wdog <= wdog + WDW'(1);
        end
        S_NEXT: begin
          if (!last_cell) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + 5'd1;
            end else begin
              col <= col + 5'd1;
            end
            map_address <= map_address + 9'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
